stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//  Packet-aware 1-to-N stream router: the receive-side counterpart of stream_arbiter.
//  Takes the merged stream (data, qos, id, last) and steers each packet to master
//  port m_*[id], with the route locked from first beat to last. Packets with
//  id >= STREAM_COUNT are accepted and discarded. Has one registered output stage
//  (latency 1, full throughput).
// PARAMETERS
//  T_DATA_WIDTH  8  width of data beat
//  T_QOS__WIDTH  4  width of qos field (carried through unchanged)
//  STREAM_COUNT  8  number of output streams; ID_W = $clog2(STREAM_COUNT), min 1
// PORTS
//  clk         in   1                 single clock, all logic on rising edge
//  rst         in   1                 synchronous, active-high reset
//  s_data_i    in   T_DATA_WIDTH      input beat data
//  s_qos_i     in   T_QOS__WIDTH      input beat qos
//  s_id_i      in   ID_W              destination; sampled on first beat of packet only
//  s_last_i    in   1                 last beat of packet
//  s_valid_i   in   1                 input beat valid
//  s_ready_o   out  1                 input beat accepted when s_valid_i & s_ready_o
//  m_data_o    out  [T_DATA_WIDTH] x STREAM_COUNT  held beat, broadcast to all ports
//  m_qos_o     out  [T_QOS__WIDTH] x STREAM_COUNT  held qos, broadcast to all ports
//  m_last_o    out  STREAM_COUNT      held last, broadcast
//  m_valid_o   out  STREAM_COUNT      one-hot (or zero): bit dest set when stage full
//  m_ready_i   in   STREAM_COUNT      per-port ready
//  drop_cnt_o  out  8                 count of discarded packets, saturates at 255
// BEHAVIOUR
//  Reset: stage empty, m_valid_o=0, m_data/qos/last=0, state IDLE, dest=0, drop_cnt_o=0.
//  Stage: hold_vld, dest, data, qos, last. free = !hold_vld | m_ready_i[dest].
//  s_ready_o = (state==DROP) | (state!=DROP & next route is droppable) | free.
//   - i.e. beats to be dropped are always accepted (s_ready_o=1); others need free.
//  Accepted non-dropped beat loads the stage next cycle (latency 1); route = s_id_i in
//   IDLE, locked_id in PKT. If the stage drains and loads in the same cycle, it is
//   replaced with no bubble.
//  If free & no load: hold_vld clears. Stage contents hold stable while
//   m_valid & !m_ready (AXI-S rules). s_ready_o may depend combinationally on m_ready_i.
//  FSM (advances only on accepted beat):
//   IDLE: id<COUNT & !last -> PKT (locked_id<=id); id<COUNT & last -> IDLE (1-beat pkt);
//         id>=COUNT & !last -> DROP; id>=COUNT & last -> IDLE; drop counted at first beat.
//   PKT : last -> IDLE; else stay. s_id_i ignored (mid-packet id change has no effect).
//   DROP: last -> IDLE; beats discarded, stage untouched, may drain independently.
//  drop_cnt_o increments once per dropped packet, on its first beat; holds at 255.
//  STREAM_COUNT power of 2: DROP unreachable; logic must still elaborate.
//  Reset mid-packet: packet truncated, stage flushed; next accepted beat is a first beat.
//  No valid asserted on more than one m_valid_o bit in any cycle.
// STRUCTURE
//  stream_pkg: typedef enum logic [1:0] {IDLE, PKT, DROP} demux_state_t; function id_w().
//  Sub-module stream_out_slice: one-entry valid/ready register (data,qos,last,dest);
//   stream_demux = FSM + route select + drop counter + stream_out_slice.
// TESTING
//  1 Reset 5 cycles, then idle -> all m_valid_o=0, s_ready_o=1, drop_cnt_o=0.
//  2 3-beat pkt id=5 (AA,BB,CC), all ready -> m_valid_o=8'h20 cycles 1..3, data AA,BB,CC, last on CC.
//  3 4-beat pkt id=2, s_id_i changed to 6 on beats 2-4 -> all 4 beats on port 2 only.
//  4 port 3 ready low 4 cycles during pkt -> s_ready_o=0, data stable, no loss; resumes 1 beat/cycle.
//  5 COUNT=6, pkt id=7 of 3 beats, then 1-beat pkt id=1 -> no m_valid for first pkt,
//    drop_cnt_o=1, second pkt on port 1.
//  6 rst asserted after beat 2 of 4-beat pkt id=4 -> stage flushed; next beat id=0 routes to port 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the packet-aware stream demultiplexer.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } demux_state_t;

  // Destination index width; a single-port build still carries a 1-bit id.
  function automatic int id_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/stream_out_slice.sv
// One-entry valid/ready output register: holds a beat plus its destination
// and presents it on exactly one master port, data broadcast to all ports.
module stream_out_slice
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 8,
  parameter int ID_W         = id_w(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_load,
  input  logic [T_DATA_WIDTH-1:0]                   i_data,
  input  logic [T_QOS__WIDTH-1:0]                   i_qos,
  input  logic                                      i_last,
  input  logic [ID_W-1:0]                           i_dest,
  output logic                                      o_free,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] o_data,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] o_qos,
  output logic [STREAM_COUNT-1:0]                   o_last,
  output logic [STREAM_COUNT-1:0]                   o_valid,
  input  logic [STREAM_COUNT-1:0]                   i_ready
);

  logic                    r_vld;
  logic [ID_W-1:0]         r_dest;
  logic [T_DATA_WIDTH-1:0] r_data;
  logic [T_QOS__WIDTH-1:0] r_qos;
  logic                    r_last;
  logic                    w_dest_rdy;

  for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_port
    assign o_valid[gi] = r_vld && (r_dest == ID_W'(gi));
    assign o_data[gi]  = r_data;
    assign o_qos[gi]   = r_qos;
    assign o_last[gi]  = r_last;
  end

  // o_valid is one-hot while full, so this picks out ready of the destination.
  assign w_dest_rdy = |(o_valid & i_ready);
  assign o_free     = !r_vld || w_dest_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_qos  <= '0;
      r_last <= 1'b0;
    end else if (o_free) begin
      r_vld <= i_load;
      if (i_load) begin
        r_dest <= i_dest;
        r_data <= i_data;
        r_qos  <= i_qos;
        r_last <= i_last;
      end
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N router: locks the route on the first beat of a packet,
// discards packets addressed beyond the last port and counts them.
module stream_demux
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 8,
  parameter int ID_W         = id_w(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [T_DATA_WIDTH-1:0]                   s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                   s_qos_i,
  input  logic [ID_W-1:0]                           s_id_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
  output logic [STREAM_COUNT-1:0]                   m_last_o,
  output logic [STREAM_COUNT-1:0]                   m_valid_o,
  input  logic [STREAM_COUNT-1:0]                   m_ready_i,
  output logic [7:0]                                drop_cnt_o
);

  demux_state_t    r_state, w_state_next;
  logic [ID_W-1:0] r_locked_id;
  logic [7:0]      r_drop_cnt;
  logic [ID_W-1:0] w_route;
  logic            w_free, w_id_bad, w_drop_beat, w_accept, w_load, w_first_bad;

  // Constant false when STREAM_COUNT fills the id space, leaving DROP unreachable.
  assign w_id_bad    = (int'(s_id_i) >= STREAM_COUNT);
  assign w_first_bad = (r_state == IDLE) && w_id_bad;
  assign w_drop_beat = (r_state == DROP) || w_first_bad;
  assign s_ready_o   = w_drop_beat || w_free;
  assign w_accept    = s_valid_i && s_ready_o;
  assign w_load      = w_accept && !w_drop_beat;
  assign w_route     = (r_state == PKT) ? r_locked_id : s_id_i;
  assign drop_cnt_o  = r_drop_cnt;

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        IDLE:    if (!s_last_i) w_state_next = w_id_bad ? DROP : PKT;
        PKT:     if (s_last_i) w_state_next = IDLE;
        DROP:    if (s_last_i) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_locked_id <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && (r_state == IDLE) && !w_id_bad) r_locked_id <= s_id_i;
      if (w_accept && w_first_bad && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  stream_out_slice #(
    .T_DATA_WIDTH (T_DATA_WIDTH),
    .T_QOS__WIDTH (T_QOS__WIDTH),
    .STREAM_COUNT (STREAM_COUNT),
    .ID_W         (ID_W)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (s_data_i),
    .i_qos   (s_qos_i),
    .i_last  (s_last_i),
    .i_dest  (w_route),
    .o_free  (w_free),
    .o_data  (m_data_o),
    .o_qos   (m_qos_o),
    .o_last  (m_last_o),
    .o_valid (m_valid_o),
    .i_ready (m_ready_i)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an 8-port build (no drops possible) and a 6-port
// build (ids 6,7 dropped), checked against a packet-level scoreboard.
`timescale 1ns/1ps
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic [3:0] s_qos = '0;
  logic [2:0] s_id = '0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       sel6 = 1'b0;
  logic       s_valid8, s_valid6, s_ready8, s_ready6, s_ready_cur;

  logic [7:0][7:0] m_data8;
  logic [7:0][3:0] m_qos8;
  logic [7:0]      m_last8, m_valid8, drop8;
  logic [7:0]      m_ready8 = 8'hFF;
  logic [5:0][7:0] m_data6;
  logic [5:0][3:0] m_qos6;
  logic [5:0]      m_last6, m_valid6;
  logic [5:0]      m_ready6 = 6'h3F;
  logic [7:0]      drop6;

  assign s_valid8    = s_valid && !sel6;
  assign s_valid6    = s_valid && sel6;
  assign s_ready_cur = sel6 ? s_ready6 : s_ready8;

  stream_demux #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(8)) u_dut8 (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id),
    .s_last_i(s_last), .s_valid_i(s_valid8), .s_ready_o(s_ready8),
    .m_data_o(m_data8), .m_qos_o(m_qos8), .m_last_o(m_last8), .m_valid_o(m_valid8),
    .m_ready_i(m_ready8), .drop_cnt_o(drop8)
  );

  stream_demux #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(6)) u_dut6 (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id),
    .s_last_i(s_last), .s_valid_i(s_valid6), .s_ready_o(s_ready6),
    .m_data_o(m_data6), .m_qos_o(m_qos6), .m_last_o(m_last6), .m_valid_o(m_valid6),
    .m_ready_i(m_ready6), .drop_cnt_o(drop6)
  );

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] data;
    logic [3:0] qos;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_drops = 0;
  int    tests = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor on the selected build: one-hot valid, hold-while-stalled,
  // and every handshaken beat matched in order against the expected queue.
  logic [7:0] mon_valid, mon_ready;
  always_comb begin
    mon_valid = sel6 ? {2'b00, m_valid6} : m_valid8;
    mon_ready = sel6 ? {2'b00, m_ready6} : m_ready8;
  end

  logic [7:0] prev_valid = '0;
  logic [7:0] prev_data = '0;
  logic       prev_stall = 1'b0;
  logic       prev_sel = 1'b0;
  always @(negedge clk) begin
    int p;
    logic [7:0] d;
    logic [3:0] q;
    logic l;
    beat_t got, want;
    p = 0;
    for (int i = 0; i < 8; i++) if (mon_valid[i]) p = i;
    if (sel6) begin d = m_data6[p]; q = m_qos6[p]; l = m_last6[p]; end
    else begin d = m_data8[p]; q = m_qos8[p]; l = m_last8[p]; end
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      tests++;
      if (!$onehot0(mon_valid)) begin
        errors++;
        $display("FAIL onehot m_valid got=%b required at most one bit", mon_valid);
      end
      if (prev_stall && prev_sel == sel6) begin
        tests++;
        if (mon_valid !== prev_valid || d !== prev_data) begin
          errors++;
          $display("FAIL stall_hold got valid=%b data=%h required valid=%b data=%h",
                   mon_valid, d, prev_valid, prev_data);
        end
      end
      if ((mon_valid & mon_ready) != 8'h00) begin
        tests++;
        got = beat_t'({3'(p), d, q, l});
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got port=%0d data=%h required no beat", p, d);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL sb_beat got port=%0d data=%h qos=%h last=%b required port=%0d data=%h qos=%h last=%b",
                     got.port, got.data, got.qos, got.last, want.port, want.data, want.qos, want.last);
          end
        end
      end
      prev_stall = (mon_valid != 8'h00) && ((mon_valid & mon_ready) == 8'h00);
    end
    prev_valid = mon_valid;
    prev_data  = d;
    prev_sel   = sel6;
  end

  // Presents one beat and returns 1ns after the edge on which it was accepted.
  task automatic drive_beat(input logic [7:0] d, input logic [3:0] q,
                            input logic [2:0] id, input logic l);
    int waitc;
    waitc = 0;
    s_data = d; s_qos = q; s_id = id; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready_cur) begin
      waitc++;
      if (waitc > 200) begin
        tests++; errors++;
        $display("FAIL accept_timeout got s_ready=0 for %0d cycles required acceptance", waitc);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] id, input int nb, input bit scramble_id);
    int cnt;
    logic [7:0] d;
    logic [3:0] q;
    logic l;
    logic [2:0] sid;
    cnt = sel6 ? 6 : 8;
    for (int b = 0; b < nb; b++) begin
      d = 8'($urandom);
      q = 4'($urandom);
      l = (b == nb - 1);
      sid = (b == 0 || !scramble_id) ? id : 3'($urandom);
      if (int'(id) < cnt) exp_q.push_back(beat_t'({id, d, q, l}));
      else if (b == 0) exp_drops++;
      drive_beat(d, q, sid, l);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (m_valid8 !== 8'h00 || m_valid6 !== 6'h00) begin
      errors++; $display("FAIL reset_valid got %h/%h required 00/00", m_valid8, m_valid6);
    end
    tests++;
    if (s_ready8 !== 1'b1 || s_ready6 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b required 1/1", s_ready8, s_ready6);
    end
    tests++;
    if (drop8 !== 8'd0 || drop6 !== 8'd0 || m_data8[0] !== 8'h00 || m_last8 !== 8'h00) begin
      errors++; $display("FAIL reset_regs got drop=%0d/%0d data=%h last=%b required zeros",
                         drop8, drop6, m_data8[0], m_last8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_three_beat();
    logic [7:0] vals [3];
    vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC;
    m_ready8 = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(beat_t'({3'd5, vals[b], 4'h3, (b == 2)}));
      drive_beat(vals[b], 4'h3, 3'd5, (b == 2));
      tests++;
      if (m_valid8 !== 8'h20 || m_data8[5] !== vals[b] || m_last8[5] !== (b == 2)) begin
        errors++;
        $display("FAIL three_beat b%0d got valid=%h data=%h last=%b required valid=20 data=%h last=%b",
                 b, m_valid8, m_data8[5], m_last8[5], vals[b], (b == 2));
      end
    end
    @(posedge clk); #1;
    tests++;
    if (m_valid8 !== 8'h00) begin
      errors++; $display("FAIL three_beat_drain got valid=%h required 00", m_valid8);
    end
  endtask

  task automatic test_id_lock();
    logic [7:0] d;
    for (int b = 0; b < 4; b++) begin
      d = 8'(8'h10 + b);
      exp_q.push_back(beat_t'({3'd2, d, 4'h7, (b == 3)}));
      drive_beat(d, 4'h7, (b == 0) ? 3'd2 : 3'd6, (b == 3));
      tests++;
      if (m_valid8 !== 8'h04) begin
        errors++; $display("FAIL id_lock b%0d got valid=%h required 04", b, m_valid8);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int c0;
    exp_q.push_back(beat_t'({3'd3, 8'h31, 4'h1, 1'b0}));
    drive_beat(8'h31, 4'h1, 3'd3, 1'b0);
    m_ready8[3] = 1'b0;
    exp_q.push_back(beat_t'({3'd3, 8'h32, 4'h1, 1'b0}));
    s_data = 8'h32; s_qos = 4'h1; s_id = 3'd3; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (s_ready8 !== 1'b0 || m_valid8 !== 8'h08 || m_data8[3] !== 8'h31) begin
        errors++;
        $display("FAIL stall c%0d got ready=%b valid=%h data=%h required ready=0 valid=08 data=31",
                 i, s_ready8, m_valid8, m_data8[3]);
      end
    end
    @(posedge clk); #1;
    m_ready8[3] = 1'b1;
    c0 = cyc;
    drive_beat(8'h32, 4'h1, 3'd3, 1'b0);
    exp_q.push_back(beat_t'({3'd3, 8'h33, 4'h1, 1'b0}));
    drive_beat(8'h33, 4'h1, 3'd3, 1'b0);
    exp_q.push_back(beat_t'({3'd3, 8'h34, 4'h1, 1'b1}));
    drive_beat(8'h34, 4'h1, 3'd3, 1'b1);
    tests++;
    if (cyc - c0 !== 3) begin
      errors++; $display("FAIL resume_rate got %0d cycles for 3 beats required 3", cyc - c0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    repeat (2) @(posedge clk);
    #1 sel6 = 1'b1;
    m_ready6 = 6'h3F;
    for (int b = 0; b < 3; b++) begin
      drive_beat(8'(8'h70 + b), 4'h2, 3'd7, (b == 2));
      tests++;
      if (m_valid6 !== 6'h00) begin
        errors++; $display("FAIL drop_novalid b%0d got valid=%b required 000000", b, m_valid6);
      end
    end
    exp_drops++;
    tests++;
    if (drop6 !== 8'd1) begin
      errors++; $display("FAIL drop_count got %0d required 1", drop6);
    end
    exp_q.push_back(beat_t'({3'd1, 8'h5A, 4'h9, 1'b1}));
    drive_beat(8'h5A, 4'h9, 3'd1, 1'b1);
    tests++;
    if (m_valid6 !== 6'b000010 || m_data6[1] !== 8'h5A) begin
      errors++; $display("FAIL after_drop got valid=%b data=%h required 000010 5A", m_valid6, m_data6[1]);
    end
    repeat (2) @(posedge clk);
    #1 sel6 = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready8 = 8'hFF;
    exp_q.push_back(beat_t'({3'd4, 8'h41, 4'h4, 1'b0}));
    drive_beat(8'h41, 4'h4, 3'd4, 1'b0);
    exp_q.push_back(beat_t'({3'd4, 8'h42, 4'h4, 1'b0}));
    drive_beat(8'h42, 4'h4, 3'd4, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    tests++;
    if (m_valid8 !== 8'h00) begin
      errors++; $display("FAIL rst_flush got valid=%h required 00", m_valid8);
    end
    exp_q.push_back(beat_t'({3'd0, 8'h01, 4'h0, 1'b1}));
    drive_beat(8'h01, 4'h0, 3'd0, 1'b1);
    tests++;
    if (m_valid8 !== 8'h01) begin
      errors++; $display("FAIL rst_first_beat got valid=%h required 01", m_valid8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input bit use6, input int npkt);
    sel6 = use6;
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < npkt; k++) begin
          send_pkt(3'($urandom_range(0, 7)), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          if (use6) m_ready6 = 6'($urandom) | 6'($urandom);
          else      m_ready8 = 8'($urandom) | 8'($urandom);
        end
      end
    join
    m_ready8 = 8'hFF;
    m_ready6 = 6'h3F;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_drain sel6=%0b got %0d beats outstanding required 0", use6, exp_q.size());
    end
    tests++;
    if ((use6 ? drop6 : drop8) !== 8'((exp_drops > 255) ? 255 : exp_drops)) begin
      errors++; $display("FAIL rnd_drops sel6=%0b got %0d required %0d", use6,
                         (use6 ? drop6 : drop8), (exp_drops > 255) ? 255 : exp_drops);
    end
  endtask

  task automatic test_drop_saturate();
    sel6 = 1'b1;
    for (int k = 0; k < 260; k++) send_pkt(3'd7, 1, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (drop6 !== 8'd255) begin
      errors++; $display("FAIL drop_saturate got %0d required 255", drop6);
    end
    sel6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_id_lock();
    test_backpressure();
    test_drop();
    test_reset_mid();
    exp_drops = 0;
    test_random(1'b0, 150);
    test_random(1'b1, 150);
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
